lsu_apb_ctrl: RTL

Sequencing controller between the MEM stage of the pipelined RISC-V core and the APB peripheral bus. It detects MEM-stage loads and stores that target the peripheral address window and runs each one as a complete APB transfer. While a transfer is in flight it stalls the pipeline by driving the enable of the EX/MEM and upstream pipeline registers low. On completion it returns read data and error status to the writeback path.

---
 rtl/lsu_apb_pkg.sv | 21 ++
 rtl/lsu_apb_ctrl_timeout_cnt.sv | 39 +++
 rtl/lsu_apb_ctrl.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/lsu_apb_pkg.sv
// ---------------------------------------------------------------------------
// lsu_apb_pkg
// Shared types and constants for the MEM-stage to APB sequencing controller.
//   - lsu_apb_state_t : controller FSM states (IDLE, SETUP, ACCESS, DONE)
//   - DEF_PERIPH_BASE / DEF_PERIPH_MASK : default peripheral window decode
//   - ERR_RDATA : read data returned to writeback on slave error / timeout
// ---------------------------------------------------------------------------
package lsu_apb_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2,
    S_DONE   = 2'd3
  } lsu_apb_state_t;

  localparam logic [31:0] DEF_PERIPH_BASE = 32'h1000_0000;
  localparam logic [31:0] DEF_PERIPH_MASK = 32'hF000_0000;
  localparam logic [31:0] ERR_RDATA       = 32'h0000_0000;

endpackage

// File: rtl/lsu_apb_ctrl_timeout_cnt.sv
// ---------------------------------------------------------------------------
// apb_timeout_cnt
// ACCESS-phase wait counter. Only instantiated when APB_TIMEOUT_EN is defined.
// Ports:
//   i_clk, i_reset : clock, synchronous active-low reset
//   i_clr          : clear the count (asserted in the cycle before ACCESS)
//   i_inc          : one ACCESS cycle elapsed without i_pready
//   o_tc           : terminal count; the increment in this cycle makes the
//                    count reach TIMEOUT_CYC
// ---------------------------------------------------------------------------
module apb_timeout_cnt #(
  parameter int TIMEOUT_CYC = 16
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_tc
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  // Fire combinationally on the increment that lands on TIMEOUT_CYC so the
  // FSM leaves ACCESS after exactly TIMEOUT_CYC non-ready cycles.
  assign o_tc = i_inc && (r_cnt == CW'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/lsu_apb_ctrl.sv
// ---------------------------------------------------------------------------
// lsu_apb_ctrl
// Runs MEM-stage loads/stores that hit the peripheral window as APB transfers
// and stalls the pipeline while a transfer is in flight.
// Optional feature macro: APB_TIMEOUT_EN (ACCESS-phase timeout with error).
// Ports:
//   i_clk, i_reset          : clock, synchronous active-low reset
//   i_req_*                 : MEM-stage request (valid, write, addr, data, strb)
//   o_stall                 : pipeline hold (combinational)
//   o_rdata, o_rdata_vld    : load data to writeback, one-cycle valid pulse
//   o_err                   : one-cycle pulse on slave error or timeout
//   o_p*, i_p*              : APB master interface
// ---------------------------------------------------------------------------
module lsu_apb_ctrl
  import lsu_apb_pkg::*;
#(
  parameter logic [31:0] PERIPH_BASE = DEF_PERIPH_BASE,
  parameter logic [31:0] PERIPH_MASK = DEF_PERIPH_MASK,
  parameter int          TIMEOUT_CYC = 16
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_req_vld,
  input  logic        i_req_wr,
  input  logic [31:0] i_req_addr,
  input  logic [31:0] i_req_wdata,
  input  logic [3:0]  i_req_strb,
  output logic        o_stall,
  output logic [31:0] o_rdata,
  output logic        o_rdata_vld,
  output logic        o_err,
  output logic        o_psel,
  output logic        o_penable,
  output logic        o_pwrite,
  output logic [31:0] o_paddr,
  output logic [31:0] o_pwdata,
  output logic [3:0]  o_pstrb,
  input  logic        i_pready,
  input  logic [31:0] i_prdata,
  input  logic        i_pslverr
);

  lsu_apb_state_t r_state;
  logic        r_psel;
  logic        r_penable;
  logic        r_pwrite;
  logic [31:0] r_paddr;
  logic [31:0] r_pwdata;
  logic [3:0]  r_pstrb;
  logic [31:0] r_rdata;
  logic        r_rdata_vld;
  logic        r_err;

  logic w_hit;
  logic w_tmo;

  assign w_hit = i_req_vld && ((i_req_addr & PERIPH_MASK) == PERIPH_BASE);

`ifdef APB_TIMEOUT_EN
  apb_timeout_cnt #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_tmo (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_clr   (r_state == S_SETUP),
    .i_inc   ((r_state == S_ACCESS) && !i_pready),
    .o_tc    (w_tmo)
  );
`else
  // No counter: ACCESS waits for i_pready indefinitely.
  logic w_unused_tmo_cfg;
  assign w_unused_tmo_cfg = (TIMEOUT_CYC != 0);
  assign w_tmo            = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state     <= S_IDLE;
      r_psel      <= 1'b0;
      r_penable   <= 1'b0;
      r_pwrite    <= 1'b0;
      r_paddr     <= '0;
      r_pwdata    <= '0;
      r_pstrb     <= '0;
      r_rdata     <= '0;
      r_rdata_vld <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_hit) begin
            r_paddr  <= i_req_addr;
            r_pwdata <= i_req_wdata;
            r_pstrb  <= i_req_wr ? i_req_strb : 4'b0000;
            r_pwrite <= i_req_wr;
            r_psel   <= 1'b1;
            r_state  <= S_SETUP;
          end
        end
        S_SETUP: begin
          r_penable <= 1'b1;
          r_state   <= S_ACCESS;
        end
        S_ACCESS: begin
          // i_pready has priority over a simultaneous timeout.
          if (i_pready || w_tmo) begin
            r_psel    <= 1'b0;
            r_penable <= 1'b0;
            r_state   <= S_DONE;
            r_err     <= i_pslverr || !i_pready;
            if (!r_pwrite) begin
              r_rdata     <= (i_pready && !i_pslverr) ? i_prdata : ERR_RDATA;
              r_rdata_vld <= 1'b1;
            end
          end
        end
        S_DONE: begin
          // The stalled instruction retires this cycle; the hit is ignored.
          r_rdata_vld <= 1'b0;
          r_err       <= 1'b0;
          r_state     <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Combinational so the hold applies in the detection cycle itself.
  assign o_stall = i_reset &&
                   (((r_state == S_IDLE) && w_hit) ||
                    (r_state == S_SETUP) || (r_state == S_ACCESS));

  assign o_psel      = r_psel;
  assign o_penable   = r_penable;
  assign o_pwrite    = r_pwrite;
  assign o_paddr     = r_paddr;
  assign o_pwdata    = r_pwdata;
  assign o_pstrb     = r_pstrb;
  assign o_rdata     = r_rdata;
  assign o_rdata_vld = r_rdata_vld;
  assign o_err       = r_err;

endmodule
